// File: rtl/pc_fetch_unit.sv
// Purpose : architectural fetch PC, instruction-fetch request and redirect handling (branch/JAL/JALR),
// Latency : redirect applied on advance appears on pc one cycle later; a buffered redirect one cycle after advance resumes.
// Backpressure: imem_ready low or stall high holds pc; a redirect arriving then is buffered (one entry, oldest wins).
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   br_pc, br_offset     - branch/JAL instruction PC and pre-shifted offset (target = br_pc + br_offset)
//   br_taken             - branch taken or JAL this cycle
//   jalr_target, jalr_sel- rs1+imm from the ALU (bit 0 cleared here) and its redirect strobe
//   halt, resume         - enter / leave the halted state (ECALL/EBREAK)
//   stall, imem_ready    - pipeline hazard hold and instruction-memory accept
//   pc, pc_plus4         - registered fetch address and its combinational successor
//   fetch_req            - fetch of pc requested (FETCH state only)
//   halted, misaligned   - in HALT / in TRAP
//   bad_addr             - redirect target that caused the trap
//   fetch_count          - number of accepted fetches, wraps modulo 2^N
module pc_fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] br_pc,
    input  logic [N-1:0] br_offset,
    input  logic         br_taken,
    input  logic [N-1:0] jalr_target,
    input  logic         jalr_sel,
    input  logic         halt,
    input  logic         resume,
    input  logic         stall,
    input  logic         imem_ready,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         fetch_req,
    output logic         halted,
    output logic         misaligned,
    output logic [N-1:0] bad_addr,
    output logic [N-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;

    // Single-entry buffer for a redirect that could not be applied immediately.
    logic         pend_valid;
    logic [N-1:0] pend_target;

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    logic [N-1:0] br_target;
    logic [N-1:0] jalr_clean;
    logic [N-1:0] redir_target;
    logic         redir;
    logic         redir_misaligned;

    assign br_target        = br_pc + br_offset;          // wraps modulo 2^N
    assign jalr_clean       = jalr_target & ~N'(1);       // JALR ignores bit 0
    assign redir            = jalr_sel | br_taken;
    assign redir_target     = jalr_sel ? jalr_clean : br_target;
    assign redir_misaligned = (redir_target[1:0] != 2'b00);

    assign pc_plus4 = pc + N'(4);

    // ------------------------------------------------------------------
    // Fetch-cycle qualifiers
    // ------------------------------------------------------------------
    logic in_fetch;
    logic advance;
    logic take_pend;    // advance consumes the buffered redirect
    logic take_redir;   // advance applies a fresh redirect
    logic latch_redir;  // fresh redirect seen while not advancing
    logic trap_now;

    assign in_fetch    = (state == S_FETCH);
    assign advance     = in_fetch & imem_ready & ~stall;
    assign take_pend   = advance & pend_valid;
    // While a redirect is buffered it belongs to an older instruction, so any
    // newer redirect is dropped, whether or not the pipeline advances.
    assign take_redir  = advance & ~pend_valid & redir;
    assign latch_redir = in_fetch & ~advance & ~pend_valid & redir;
    // Alignment is checked when the target is first seen, so a buffered
    // target is always aligned by construction.
    assign trap_now    = (take_redir | latch_redir) & redir_misaligned;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // A trap outranks halt: the faulting target must be reported.
                if (trap_now) begin
                    state_nxt = S_TRAP;
                end else if (halt) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_nxt = S_FETCH;
                end
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register, so they only change
    // on the clock edge)
    // ------------------------------------------------------------------
    always_comb begin
        fetch_req  = 1'b0;
        halted     = 1'b0;
        misaligned = 1'b0;
        unique case (state)
            S_FETCH: fetch_req  = 1'b1;
            S_HALT:  halted     = 1'b1;
            S_TRAP:  misaligned = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // PC, redirect buffer, trap address and fetch counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            bad_addr    <= '0;
            fetch_count <= '0;
        end else begin
            if (advance) begin
                fetch_count <= fetch_count + N'(1);
            end

            // Next-PC selection on advance; pc is still updated when halt is
            // raised in the same cycle so that it becomes the resume point.
            if (take_pend) begin
                pc         <= pend_target;
                pend_valid <= 1'b0;
            end else if (take_redir) begin
                if (!redir_misaligned) begin
                    pc <= redir_target;
                end
            end else if (advance) begin
                pc <= pc_plus4;
            end

            if (latch_redir && !redir_misaligned) begin
                pend_valid  <= 1'b1;
                pend_target <= redir_target;
            end

            if (trap_now) begin
                bad_addr <= redir_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (N=32/RESET_PC=0 and N=8/RESET_PC=0xF8) share one stimulus stream.
// A reference model per instance predicts each cycle's outputs into a queue; a monitor pops and compares.
// Directed spec scenarios are followed by randomized traffic with occasional resets, halts and misaligned targets.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, br_taken, jalr_sel, halt, resume, stall, imem_ready;
    logic [31:0] br_pc, br_offset, jalr_target;

    logic [31:0] pc32, p4_32, bad32, cnt32;
    logic        fr32, h32, m32o;
    logic [7:0]  pc8, p4_8, bad8, cnt8;
    logic        fr8, h8, m8o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.N(32), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .rst(rst), .br_pc(br_pc), .br_offset(br_offset), .br_taken(br_taken),
        .jalr_target(jalr_target), .jalr_sel(jalr_sel), .halt(halt), .resume(resume),
        .stall(stall), .imem_ready(imem_ready), .pc(pc32), .pc_plus4(p4_32),
        .fetch_req(fr32), .halted(h32), .misaligned(m32o), .bad_addr(bad32), .fetch_count(cnt32)
    );

    pc_fetch_unit #(.N(8), .RESET_PC(8'hF8)) dut8 (
        .clk(clk), .rst(rst), .br_pc(br_pc[7:0]), .br_offset(br_offset[7:0]), .br_taken(br_taken),
        .jalr_target(jalr_target[7:0]), .jalr_sel(jalr_sel), .halt(halt), .resume(resume),
        .stall(stall), .imem_ready(imem_ready), .pc(pc8), .pc_plus4(p4_8),
        .fetch_req(fr8), .halted(h8), .misaligned(m8o), .bad_addr(bad8), .fetch_count(cnt8)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit booting, stopped, trapped, has_pend;
        longint unsigned pc, cnt, bad, pend;
    } mdl_t;

    typedef struct {
        longint unsigned pc, p4, bad, cnt;
        bit freq, hlt, mis;
    } exp_t;

    mdl_t m32, m8;
    exp_t q32[$];
    exp_t q8[$];

    function automatic mdl_t mstep(mdl_t m, longint unsigned msk, longint unsigned rpc);
        mdl_t n = m;
        longint unsigned tgt;
        bit adv, want;
        if (rst) begin
            n.booting = 1; n.stopped = 0; n.trapped = 0; n.has_pend = 0;
            n.pc = rpc; n.cnt = 0; n.bad = 0; n.pend = 0;
            return n;
        end
        if (m.booting) begin n.booting = 0; return n; end
        if (m.trapped) return n;
        if (m.stopped) begin
            if (resume) n.stopped = 0;
            return n;
        end
        adv  = imem_ready && !stall;
        want = jalr_sel || br_taken;
        if (jalr_sel) tgt = (longint'(jalr_target) & msk) & ~64'd1;
        else          tgt = (longint'(br_pc) + longint'(br_offset)) & msk;
        if (adv) begin
            n.cnt = (m.cnt + 1) & msk;
            if (m.has_pend) begin
                n.pc = m.pend; n.has_pend = 0;
            end else if (want) begin
                if (tgt % 4 != 0) begin n.trapped = 1; n.bad = tgt; end
                else n.pc = tgt;
            end else begin
                n.pc = (m.pc + 4) & msk;
            end
        end else if (want && !m.has_pend) begin
            if (tgt % 4 != 0) begin n.trapped = 1; n.bad = tgt; end
            else begin n.has_pend = 1; n.pend = tgt; end
        end
        if (halt && !n.trapped) n.stopped = 1;
        return n;
    endfunction

    function automatic exp_t snap(mdl_t m, longint unsigned msk);
        exp_t e;
        e.pc   = m.pc;
        e.p4   = (m.pc + 4) & msk;
        e.bad  = m.bad;
        e.cnt  = m.cnt;
        e.freq = !m.booting && !m.stopped && !m.trapped;
        e.hlt  = m.stopped;
        e.mis  = m.trapped;
        return e;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q32.size() > 0) begin
                e = q32.pop_front();
                chk("n32.pc", pc32, e.pc);            chk("n32.pc_plus4", p4_32, e.p4);
                chk("n32.fetch_req", fr32, e.freq);   chk("n32.halted", h32, e.hlt);
                chk("n32.misaligned", m32o, e.mis);   chk("n32.bad_addr", bad32, e.bad);
                chk("n32.fetch_count", cnt32, e.cnt);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("n8.pc", pc8, e.pc);              chk("n8.pc_plus4", p4_8, e.p4);
                chk("n8.fetch_req", fr8, e.freq);     chk("n8.halted", h8, e.hlt);
                chk("n8.misaligned", m8o, e.mis);     chk("n8.bad_addr", bad8, e.bad);
                chk("n8.fetch_count", cnt8, e.cnt);
            end
        end
    end

    // ---------------- driver ----------------
    // Applies one cycle of inputs, predicts the post-edge outputs, then waits for the next negedge.
    task automatic drive(input bit r, input bit rdy, input bit st, input bit bt,
                         input logic [31:0] bpc, input logic [31:0] boff,
                         input bit js, input logic [31:0] jt, input bit h, input bit rs);
        rst = r; imem_ready = rdy; stall = st; br_taken = bt; br_pc = bpc; br_offset = boff;
        jalr_sel = js; jalr_target = jt; halt = h; resume = rs;
        m32 = mstep(m32, 64'hFFFF_FFFF, 64'h0);
        m8  = mstep(m8, 64'hFF, 64'hF8);
        q32.push_back(snap(m32, 64'hFFFF_FFFF));
        q8.push_back(snap(m8, 64'hFF));
        @(negedge clk);
    endtask

    task automatic adv();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] off, jt;
        m32 = '{default: 0};
        m8  = '{default: 0};

        // Reset, then the BOOT cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.fetch_req", fr32, 0);
        chk("reset.pc", pc32, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("boot.fetch_req", fr32, 1);

        // Sequential fetch; the 8-bit instance wraps 0xFC -> 0x00.
        for (int i = 0; i < 4; i++) begin
            chk("seq.pc", pc32, 4 * i);
            chk("seq.pc_plus4", p4_32, 4 * i + 4);
            chk("seq.pc8", pc8, (248 + 4 * i) % 256);
            adv();
        end
        chk("seq.fetch_count", cnt32, 4);

        // Branch, then JALR beating a branch in the same cycle.
        drive(0, 1, 0, 1, 32'h8, 32'h20, 0, 0, 0, 0);
        chk("branch.pc", pc32, 32'h28);
        drive(0, 1, 0, 1, 32'h8, 32'h20, 1, 32'h101, 0, 0);
        chk("jalr.pc", pc32, 32'h100);

        // Buffered redirect: branch during stall kept, later JALR dropped.
        drive(0, 1, 1, 1, 32'h40, 32'h0, 0, 0, 0, 0);
        chk("buf.hold1", pc32, 32'h100);
        drive(0, 1, 1, 0, 0, 0, 1, 32'h80, 0, 0);
        chk("buf.hold2", pc32, 32'h100);
        adv();
        chk("buf.release", pc32, 32'h40);

        // Halt at pc 0x20 with advance; inputs other than resume are ignored.
        drive(0, 1, 0, 1, 32'h20, 32'h0, 0, 0, 0, 0);
        chk("halt.setup", pc32, 32'h20);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("halt.pc", pc32, 32'h24);
            chk("halt.halted", h32, 1);
            chk("halt.fetch_req", fr32, 0);
            chk("halt.count", cnt32, 9);
            drive(0, $urandom % 2, $urandom % 2, 1, 32'h4, 32'h2, $urandom % 2, $urandom, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("resume.fetch_req", fr32, 1);
        chk("resume.pc", pc32, 32'h24);
        chk("resume.count", cnt32, 9);

        // Misaligned branch target 0x6.
        drive(0, 1, 0, 1, 32'h4, 32'h2, 0, 0, 0, 0);
        chk("trap.misaligned", m32o, 1);
        chk("trap.bad_addr", bad32, 32'h6);
        chk("trap.fetch_req", fr32, 0);
        chk("trap.pc", pc32, 32'h24);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("trap.rst_pc", pc32, 0);
        chk("trap.rst_mis", m32o, 0);

        // Reset while a redirect is buffered: the buffered target must be lost.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        drive(0, 1, 1, 1, 32'h40, 32'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstpend.pc8", pc8, 8'hF8);
        chk("rstpend.cnt8", cnt8, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        chk("rstpend.next_pc8", pc8, 8'hFC);
        chk("rstpend.next_pc32", pc32, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            off = $urandom;
            off[0] = 1'b0;
            if ($urandom % 12 != 0) off[1] = 1'b0;
            jt = $urandom;
            if ($urandom % 12 != 0) jt[1] = 1'b0;
            drive($urandom % 60 == 0, $urandom % 4 != 0, $urandom % 5 == 0, $urandom % 6 == 0,
                  $urandom & 32'hFFFF_FFFC, off, $urandom % 8 == 0, jt,
                  $urandom % 30 == 0, $urandom % 4 == 0);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard.drained", q32.size() + q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
